fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_queue.sv | 70 +++++++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam int XLEN_DEFAULT = 32;
  localparam int INSTR_W      = 32;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO: power-of-two depth, flush beats push/pop, head visible combinationally.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  input  logic                           flush,
  output logic [WIDTH-1:0]               head_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are DEPTH-sized, so natural overflow is the modulo wrap.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; emptiness is tracked by count_q, and a reset here would block RAM mapping.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word fetches, buffers in-order responses, redirects on taken control flow.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter int              QDEPTH       = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redir_valid,
  input  logic               redir_use_rs1,
  input  logic [XLEN-1:0]    redir_pc,
  input  logic [XLEN-1:0]    redir_rs1,
  input  logic [XLEN-1:0]    redir_imm,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [XLEN-1:0]    dec_pc,
  output logic [XLEN-1:0]    dec_pc_plus4,
  output logic               misalign_err
);

  localparam int CW = $clog2(QDEPTH+1);
  localparam int QW = INSTR_W + XLEN;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] redir_sum, redir_target;
  logic            redir_mis;
  logic            req_fire, rsp_in, dec_fire, q_push;
  logic [XLEN-1:0] rsp_pc;
  logic [QW-1:0]   q_head;
  logic [CW-1:0]   q_count;
  logic            q_full, q_empty;

  always_comb begin
    redir_sum = (redir_use_rs1 ? redir_rs1 : redir_pc) + redir_imm;
    if (redir_use_rs1) redir_sum[0] = 1'b0;
    redir_mis    = redir_sum[1];
    redir_target = redir_sum;
    redir_target[1:0] = 2'b00;
  end

  assign imem_req_valid = (state_q == RUN) && !q_full &&
                          ((int'(q_count) + int'(outst_q)) < QDEPTH);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_in         = imem_rsp_valid && (outst_q != '0);
  assign dec_fire       = dec_valid && dec_ready;
  assign q_push         = rsp_in && (state_q == RUN) && !redir_valid;

  // In RUN the in-flight requests cover consecutive words ending just below pc_q,
  // so the oldest one (the response arriving now) sits outst_q words back.
  assign rsp_pc = pc_q - (XLEN'(outst_q) << 2);

  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(rsp_in);
    misalign_d = redir_valid && redir_mis;

    if (req_fire) pc_d = pc_q + XLEN'(4);

    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      DRAIN:   if (outst_d == '0) state_d = RUN;
      default: state_d = BOOT;
    endcase

    // Redirect wins over everything else this cycle; in-flight work is drained, not cancelled.
    if (redir_valid) begin
      pc_d    = redir_target;
      state_d = (outst_d != '0) ? DRAIN : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      outst_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      outst_q    <= outst_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_queue #(
    .WIDTH (QW),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data ({imem_rsp_data, rsp_pc}),
    .pop       (dec_fire),
    .flush     (redir_valid),
    .head_data (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign dec_valid    = !q_empty;
  assign dec_instr    = q_head[QW-1:XLEN];
  assign dec_pc       = q_head[XLEN-1:0];
  assign dec_pc_plus4 = dec_pc + XLEN'(4);
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order latency-configurable memory model, redirect vector table, corner sequences.
module tb_fetch_unit;

  localparam int          XLEN   = 32;
  localparam int          QDEPTH = 4;
  localparam logic [31:0] RV     = 32'h0000_0000;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redir_valid, redir_use_rs1;
  logic [31:0] redir_pc, redir_rs1, redir_imm;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr, dec_pc, dec_pc_plus4;
  logic        misalign_err;

  fetch_unit #(
    .XLEN         (XLEN),
    .QDEPTH       (QDEPTH),
    .RESET_VECTOR (RV)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redir_valid    (redir_valid),
    .redir_use_rs1  (redir_use_rs1),
    .redir_pc       (redir_pc),
    .redir_rs1      (redir_rs1),
    .redir_imm      (redir_imm),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_pc_plus4   (dec_pc_plus4),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: accepted requests answered in order, mem_lat cycles after acceptance.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t pend[$];
  int    cyc      = 0;
  int    mem_lat  = 1;
  int    n_accept = 0;
  int    n_rsp    = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0003;
  endfunction

  task automatic tick();
    logic        acc, rv, r;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    rv  = imem_rsp_valid;
    r   = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      pend.delete();
    end else begin
      if (rv && pend.size() > 0) begin
        pend.delete(0);
        n_rsp++;
      end
      if (acc) begin
        pend.push_back('{addr: a, due: cyc + mem_lat - 1});
        n_accept++;
      end
    end
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset(input int n);
    rst         = 1'b1;
    redir_valid = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic wait_dec(input int max, output logic ok, output int waited);
    waited = 0;
    while (dec_valid !== 1'b1 && waited < max) begin
      tick();
      waited++;
    end
    ok = (dec_valid === 1'b1);
  endtask

  task automatic redirect(input logic use_rs1, input logic [31:0] pc, input logic [31:0] rs1,
                          input logic [31:0] imm);
    redir_use_rs1 = use_rs1;
    redir_pc      = pc;
    redir_rs1     = rs1;
    redir_imm     = imm;
    redir_valid   = 1'b1;
    tick();
    redir_valid   = 1'b0;
  endtask

  typedef struct {
    logic        use_rs1;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [31:0] exp_addr;
    logic        exp_mis;
  } redir_vec_t;

  redir_vec_t vecs[9];

  initial begin
    logic ok;
    int   w;
    int   rsp_base;

    vecs[0] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 32'hFFFF_FFF8, 32'h0000_00F8, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0000, 32'h0000_0203, 32'h0000_0000, 32'h0000_0200, 1'b1};
    vecs[2] = '{1'b0, 32'h0000_1000, 32'h0000_0000, 32'h0000_0020, 32'h0000_1020, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0000, 32'h0000_0301, 32'h0000_0004, 32'h0000_0304, 1'b0};
    vecs[4] = '{1'b0, 32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_0014, 32'h0000_0004, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0000, 32'h0000_0010, 32'hFFFF_FFF2, 32'h0000_0000, 1'b1};
    vecs[6] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 32'h0000_0002, 32'h0000_0040, 1'b1};
    vecs[7] = '{1'b1, 32'h0000_0500, 32'h0000_0100, 32'h0000_0008, 32'h0000_0108, 1'b0};
    vecs[8] = '{1'b0, 32'h0000_0500, 32'h0000_7777, 32'h0000_0008, 32'h0000_0508, 1'b0};

    rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redir_valid = 1'b0; redir_use_rs1 = 1'b0; redir_pc = '0; redir_rs1 = '0; redir_imm = '0;
    dec_ready = 1'b1;

    // Reset release, latency 1, ready always high.
    mem_lat = 1;
    tick();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_addr", imem_req_addr, RV);
    tick();
    rst = 1'b0;
    check("boot_req_valid", 32'(imem_req_valid), 32'd0);
    check("boot_addr", imem_req_addr, RV);
    wait_dec(10, ok, w);
    check("first_dec_timeout", 32'(ok), 32'd1);
    check("first_dec_latency", 32'(w), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stream_pc%0d", i), dec_pc, 32'(4 * i));
      check($sformatf("stream_instr%0d", i), dec_instr, instr_of(32'(4 * i)));
      check($sformatf("stream_plus4_%0d", i), dec_pc_plus4, 32'(4 * i + 4));
      tick();
    end

    // Redirect target table, taken from steady streaming.
    for (int i = 0; i < 9; i++) begin
      redirect(vecs[i].use_rs1, vecs[i].pc, vecs[i].rs1, vecs[i].imm);
      check($sformatf("v%0d_addr", i), imem_req_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_misalign", i), 32'(misalign_err), 32'(vecs[i].exp_mis));
      tick();
      check($sformatf("v%0d_misalign_clear", i), 32'(misalign_err), 32'd0);
      wait_dec(20, ok, w);
      check($sformatf("v%0d_dec_timeout", i), 32'(ok), 32'd1);
      check($sformatf("v%0d_dec_pc", i), dec_pc, vecs[i].exp_addr);
      check($sformatf("v%0d_dec_instr", i), dec_instr, instr_of(vecs[i].exp_addr));
      repeat (2) tick();
    end

    // Decode stalled: the queue fills to QDEPTH and the head holds.
    dec_ready = 1'b0;
    do_reset(2);
    n_accept = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dec_valid === 1'b1) begin
        check($sformatf("stall_pc%0d", i), dec_pc, 32'h0);
        check($sformatf("stall_instr%0d", i), dec_instr, instr_of(32'h0));
      end
    end
    check("stall_accepts", 32'(n_accept), 32'(QDEPTH));
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    dec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("unstall_pc%0d", i), dec_pc, 32'(4 * i));
      tick();
    end

    // Branch with two responses in flight: both dropped, then fetch from 0xF8.
    mem_lat = 3;
    do_reset(2);
    n_accept = 0;
    for (int i = 0; i < 10 && n_accept < 2; i++) tick();
    check("drain_pre_accepts", 32'(n_accept), 32'd2);
    imem_req_ready = 1'b0;
    rsp_base = n_rsp;
    redirect(1'b0, 32'h0000_0100, 32'h0, 32'hFFFF_FFF8);
    imem_req_ready = 1'b1;
    check("drain_addr", imem_req_addr, 32'h0000_00F8);
    check("drain_req_valid", 32'(imem_req_valid), 32'd0);
    wait_dec(30, ok, w);
    check("drain_dec_timeout", 32'(ok), 32'd1);
    check("drain_dec_pc", dec_pc, 32'h0000_00F8);
    check("drain_rsp_count", 32'(n_rsp - rsp_base), 32'd3);

    // Redirect colliding with dec handshake and response push, no request accepted.
    mem_lat = 1;
    do_reset(2);
    wait_dec(10, ok, w);
    repeat (3) tick();
    check("same_pre_dec_valid", 32'(dec_valid), 32'd1);
    imem_req_ready = 1'b0;
    redirect(1'b0, 32'h0000_0400, 32'h0, 32'h0);
    imem_req_ready = 1'b1;
    check("same_a_dec_valid", 32'(dec_valid), 32'd0);
    check("same_a_req_valid", 32'(imem_req_valid), 32'd1);
    check("same_a_addr", imem_req_addr, 32'h0000_0400);
    wait_dec(10, ok, w);
    check("same_a_dec_pc", dec_pc, 32'h0000_0400);

    // Same collision, but a request is also accepted: it stays outstanding.
    repeat (3) tick();
    redirect(1'b0, 32'h0000_0480, 32'h0, 32'h0);
    check("same_b_dec_valid", 32'(dec_valid), 32'd0);
    check("same_b_req_valid", 32'(imem_req_valid), 32'd0);
    check("same_b_addr", imem_req_addr, 32'h0000_0480);
    tick();
    check("same_b_req_valid_run", 32'(imem_req_valid), 32'd1);
    wait_dec(10, ok, w);
    check("same_b_dec_pc", dec_pc, 32'h0000_0480);

    // Reset while draining: nothing stale may reach decode.
    mem_lat = 3;
    do_reset(2);
    n_accept = 0;
    for (int i = 0; i < 10 && n_accept < 2; i++) tick();
    imem_req_ready = 1'b0;
    redirect(1'b0, 32'h0000_0300, 32'h0, 32'h0);
    imem_req_ready = 1'b1;
    check("rdrain_req_valid", 32'(imem_req_valid), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rdrain_boot_req", 32'(imem_req_valid), 32'd0);
    check("rdrain_boot_dec", 32'(dec_valid), 32'd0);
    check("rdrain_boot_addr", imem_req_addr, RV);
    wait_dec(30, ok, w);
    check("rdrain_dec_timeout", 32'(ok), 32'd1);
    check("rdrain_dec_pc", dec_pc, RV);
    check("rdrain_dec_instr", dec_instr, instr_of(RV));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, time %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
